// File: rtl/fetch_queue_pkg.sv
// Shared types and defaults for the instruction fetch queue.
package fetch_queue_pkg;

  parameter logic [31:0] FQ_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  typedef enum logic {
    FQ_RUN   = 1'b0,
    FQ_DRAIN = 1'b1
  } fq_state_t;

endpackage

// File: rtl/fq_fifo.sv
// Synchronous DEPTH-entry FIFO of fetch entries; clear empties it in one cycle.
import fetch_queue_pkg::*;

module fq_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  fetch_entry_t             wdata,
  output fetch_entry_t             head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t   mem [DEPTH];
  logic [AW-1:0]  rd_ptr;
  logic [AW-1:0]  wr_ptr;
  logic           do_push;
  logic           do_pop;

  assign empty   = (count == CW'(0));
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  // Entry storage, no reset needed since head is masked while empty.
  always_ff @(posedge clk) begin
    if (do_push && !clear) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue: one outstanding imem request, redirect with drain of a stale response.
// Optional macro FETCH_QUEUE_STATS_EN adds the fetch_stall_cycles counter output.
import fetch_queue_pkg::*;

module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = FQ_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stallD,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        validD
`ifdef FETCH_QUEUE_STATS_EN
  ,
  output logic [31:0] fetch_stall_cycles
`endif
);

  localparam int          CW      = $clog2(DEPTH) + 1;
  localparam logic [31:0] PC_MASK = 32'hFFFF_FFFC;

  fq_state_t     state;
  fq_state_t     next_state;
  logic [31:0]   fetch_pc;
  logic [31:0]   next_fetch_pc;
  logic [31:0]   pending_pc;
  logic [31:0]   next_pending_pc;
  logic [31:0]   target_pc;
  logic          ack;
  logic          push;
  logic          pop;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  fetch_entry_t  new_entry;
  fetch_entry_t  head;

  assign target_pc = redirect_pc & PC_MASK;
  assign imem_req  = ~reset & ((state == FQ_DRAIN) | (count < CW'(DEPTH)));
  assign imem_addr = fetch_pc;
  assign ack       = imem_req & imem_ack;
  assign push      = (state == FQ_RUN) & ack & ~redirect & ~full;
  assign pop       = ~empty & ~stallD & ~redirect;
  assign new_entry = '{pc: fetch_pc, instr: imem_rdata};

  fq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .clear (redirect),
    .wdata (new_entry),
    .head  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign validD   = ~empty;
  assign InstrD   = validD ? head.instr : 32'h0000_0000;
  assign PCD      = validD ? head.pc : 32'h0000_0000;
  assign PCPlus4D = validD ? (head.pc + 32'd4) : 32'h0000_0000;

  // Fetch FSM state and address registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= FQ_RUN;
      fetch_pc   <= RESET_PC & PC_MASK;
      pending_pc <= 32'h0000_0000;
    end else begin
      state      <= next_state;
      fetch_pc   <= next_fetch_pc;
      pending_pc <= next_pending_pc;
    end
  end

  // A redirect that catches a request in flight must let that response land before moving on.
  always_comb begin
    next_state      = state;
    next_fetch_pc   = fetch_pc;
    next_pending_pc = pending_pc;
    case (state)
      FQ_RUN: begin
        if (redirect) begin
          if (imem_req && !imem_ack) begin
            next_state      = FQ_DRAIN;
            next_pending_pc = target_pc;
          end else begin
            next_fetch_pc = target_pc;
          end
        end else if (ack) begin
          next_fetch_pc = fetch_pc + 32'd4;
        end else begin
          next_fetch_pc = fetch_pc;
        end
      end
      FQ_DRAIN: begin
        if (redirect) begin
          next_pending_pc = target_pc;
        end else begin
          next_pending_pc = pending_pc;
        end
        if (ack) begin
          next_state    = FQ_RUN;
          next_fetch_pc = redirect ? target_pc : pending_pc;
        end else begin
          next_state = FQ_DRAIN;
        end
      end
      default: begin
        next_state = FQ_RUN;
      end
    endcase
  end

`ifdef FETCH_QUEUE_STATS_EN
  // Saturating count of cycles with nothing for decode.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_stall_cycles <= 32'h0000_0000;
    end else if (!validD && (fetch_stall_cycles != 32'hFFFF_FFFF)) begin
      fetch_stall_cycles <= fetch_stall_cycles + 32'd1;
    end else begin
      fetch_stall_cycles <= fetch_stall_cycles;
    end
  end
`endif

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of FIFO entries (power of two, 2..16).
REQ-002 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-003 One clock; reset is asynchronous and active-high; ports named clk and reset.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  asynchronous active-high reset.
REQ-006 redirect  input  1  branch/PC-write redirect from the execute/writeback stage.
REQ-007 redirect_pc  input  32  new fetch address, valid when redirect=1.
REQ-008 stallD  input  1  decode stage cannot accept an instruction this cycle.
REQ-009 imem_req  output  1  instruction memory request.
REQ-010 imem_addr  output  32  word-aligned request address.
REQ-011 imem_ack  input  1  response valid; completes the outstanding request.
REQ-012 imem_rdata  input  32  instruction word, valid when imem_ack=1.
REQ-013 InstrD  output  32  instruction presented to decode.
REQ-014 PCD  output  32  address of InstrD.
REQ-015 PCPlus4D  output  32  PCD+4.
REQ-016 validD  output  1  InstrD/PCD/PCPlus4D are meaningful.

Function
REQ-017 At most one memory request outstanding; imem_ack with imem_req=0 is ignored.
REQ-018 imem_req and imem_addr are held stable from assertion until the cycle imem_ack=1; imem_ack can arrive in the same cycle as imem_req (zero wait).
REQ-019 A new request is raised only when (entries + outstanding) < DEPTH; no overflow under any input pattern.
REQ-020 On acknowledged request: push {imem_addr, imem_rdata}, fetch_pc += 4 (32-bit wrap, 32'hFFFF_FFFC -> 0).
REQ-021 Decode side: head entry drives InstrD/PCD; validD = !empty; pop when validD & !stallD.
REQ-022 When validD=0, InstrD, PCD, PCPlus4D are driven to 0.
REQ-023 Push and pop in the same cycle keep occupancy unchanged, including when full.
REQ-024 stallD while empty has no effect.
REQ-025 FSM states: RUN (normal), DRAIN (discard one in-flight response).
REQ-026 redirect has priority over push and pop: FIFO cleared, fetch_pc <= redirect_pc, validD=0 next cycle.
REQ-027 redirect with request outstanding and imem_ack=0: RUN -> DRAIN; imem_req/imem_addr stay on the old address; the response is discarded on ack; DRAIN -> RUN on ack, next request to redirect_pc.
REQ-028 redirect in the same cycle as imem_ack: the returned word is discarded; stay in RUN.
REQ-029 redirect while in DRAIN: latch the newest redirect_pc; remain in DRAIN until ack.
REQ-030 redirect_pc[1:0] is ignored (forced to 2'b00).

Reset
REQ-031 On reset: FSM=RUN, FIFO empty, outstanding=0, fetch_pc=RESET_PC, validD=0, InstrD=PCD=PCPlus4D=0, imem_req=0.
REQ-032 First imem_req=1 with imem_addr=RESET_PC in the first cycle after reset deasserts.
REQ-033 Reset asserted mid-request abandons the request; a later imem_ack for it is ignored.

Configuration
REQ-034 Macro FETCH_QUEUE_STATS_EN: when defined, add output fetch_stall_cycles (32) counting cycles with validD=0 and reset=0, saturating at 32'hFFFF_FFFF, reset to 0.
REQ-035 Without FETCH_QUEUE_STATS_EN the port and counter do not exist; all other behaviour identical.

Structure
REQ-036 Shared package holds typedef fetch_entry_t {pc[31:0], instr[31:0]}, FSM enum fq_state_t {FQ_RUN, FQ_DRAIN}, and constant FQ_RESET_PC default.
REQ-037 One sub-module, fq_fifo: synchronous DEPTH-entry FIFO of fetch_entry_t with push, pop, clear, full, empty, count.

Verification
REQ-038 Reset, ack same-cycle always, stallD=0 -> addresses 0,4,8,...; validD=1 from cycle 2, PCD tracks, PCPlus4D=PCD+4.
REQ-039 stallD=1 for 10 cycles, ack always -> exactly 4 entries held, imem_req=0 while full, no instruction lost or duplicated on release.
REQ-040 Request to 0x10 with ack delayed 3 cycles, redirect to 0x200 in cycle 1 -> imem_addr stays 0x10 until ack, word discarded, next request 0x200, first validD has PCD=0x200.
REQ-041 redirect to 0x100 coincident with ack of 0x20 -> 0x20 word never reaches decode; next PCD=0x100.
REQ-042 fetch_pc=32'hFFFF_FFFC -> next request address 0x0000_0000.
REQ-043 With FETCH_QUEUE_STATS_EN, 5 empty cycles after redirect -> fetch_stall_cycles increases by exactly 5.
